muldiv_seq: RTL and testbench

- Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers for the MIPS core.
- Performs no add/subtract itself: each iteration drives the shared 32-bit ALU (A, B, ALUCtrl in; result out) with ADDU or SUBU.
- Presents a start/busy/done handshake to the core controller.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 41 ++++
 rtl/muldiv_seq.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle MULT/DIV sequencer: op codes, FSM states
// and the shared-ALU opcodes it drives.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUBU = 4'b0011;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for muldiv_seq: magnitude of the operands before iterating and
// conditional negation of the raw result afterwards.
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic            signed_op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic [XLEN-1:0] rs_abs,
  output logic [XLEN-1:0] rt_abs,
  output logic            rs_neg,
  output logic            rt_neg,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic            neg_wide,
  input  logic            neg_hi,
  input  logic            neg_lo,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  localparam int W2 = 2 * XLEN;

  logic [W2-1:0] wide_neg;

  always_comb begin
    rs_neg   = signed_op & rs[XLEN-1];
    rt_neg   = signed_op & rt[XLEN-1];
    rs_abs   = rs_neg ? (~rs + XLEN'(1)) : rs;
    rt_abs   = rt_neg ? (~rt + XLEN'(1)) : rt;
    wide_neg = ~{hi_in, lo_in} + W2'(1);
    // Multiply negates the 64-bit product; divide negates quotient and remainder separately.
    if (neg_wide) begin
      {hi_out, lo_out} = wide_neg;
    end else begin
      hi_out = neg_hi ? (~hi_in + XLEN'(1)) : hi_in;
      lo_out = neg_lo ? (~lo_in + XLEN'(1)) : lo_in;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO, iterating on the shared ALU.
// Define MULDIV_PERF_EN to add the saturating busy-cycle counter output perf_cycles.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
`ifdef MULDIV_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int CW = $clog2(XLEN);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] rs_q, rs_d;
  logic [XLEN-1:0] rt_q, rt_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_neg_q, rs_neg_d;
  logic            res_neg_q, res_neg_d;

  logic [XLEN-1:0] rs_abs, rt_abs, fix_hi, fix_lo;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] sh;
  logic            ge, carry;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .signed_op (op_q[0]),
    .rs        (rs_q),
    .rt        (rt_q),
    .rs_abs    (rs_abs),
    .rt_abs    (rt_abs),
    .rs_neg    (rs_neg),
    .rt_neg    (rt_neg),
    .hi_in     (hi_q),
    .lo_in     (lo_q),
    .neg_wide  ((op_q == OP_MULT) & res_neg_q),
    .neg_hi    ((op_q == OP_DIV) & rs_neg_q),
    .neg_lo    ((op_q == OP_DIV) & res_neg_q),
    .hi_out    (fix_hi),
    .lo_out    (fix_lo)
  );

  assign busy = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    rs_neg_d  = rs_neg_q;
    res_neg_d = res_neg_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_ADDU;
    // The divide remainder is effectively XLEN+1 bits: hi[MSB] set means sh >= divisor.
    sh        = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    ge        = hi_q[XLEN-1] | (sh >= opnd_q);
    carry     = lo_q[0] & (alu_result < hi_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          rs_d    = rs_val;
          rt_d    = rt_val;
          state_d = PREP;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      PREP: begin
        rs_neg_d  = rs_neg;
        res_neg_d = rs_neg ^ rt_neg;
        cnt_d     = '0;
        hi_d      = '0;
        if (op_q[1]) begin
          if (rt_q == '0) begin
            hi_d    = rs_q;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            opnd_d  = rt_abs;
            lo_d    = rs_abs;
            state_d = ITER;
          end
        end else begin
          opnd_d  = rs_abs;
          lo_d    = rt_abs;
          state_d = ITER;
        end
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          alu_a    = sh;
          alu_b    = opnd_q;
          alu_ctrl = ALU_SUBU;
          hi_d     = ge ? alu_result : sh;
          lo_d     = {lo_q[XLEN-2:0], ge};
        end else begin
          alu_a    = hi_q;
          alu_b    = lo_q[0] ? opnd_q : '0;
          alu_ctrl = ALU_ADDU;
          hi_d     = {carry, alu_result[XLEN-1:1]};
          lo_d     = {alu_result[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MULTU;
      rs_q      <= '0;
      rt_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      rs_neg_q  <= 1'b0;
      res_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      rs_neg_q  <= rs_neg_d;
      res_neg_q <= res_neg_d;
    end
  end

`ifdef MULDIV_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random MULT/DIV operations scored against
// plain 64-bit arithmetic, plus HI/LO write, reset and handshake timing checks.
module tb_muldiv_seq;

  localparam logic [3:0] ADDU = 4'b0001;
  localparam logic [3:0] SUBU = 4'b0011;

  logic        clk, rst, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
`ifdef MULDIV_PERF_EN
  logic [31:0] perf_cycles;
`endif

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_cyc;
    int          lat;
    int          busy_n;
    int          addu_n;
    int          subu_n;
  } exp_t;

  exp_t        exp_q[$];
  int          tests, fails, cyc, busy_n, addu_n, subu_n, idle_bad, exp_perf;
  logic [31:0] model_hi, model_lo;

  muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
`ifdef MULDIV_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  // Shared ALU stand-in
  assign alu_result = (alu_ctrl == ADDU) ? alu_a + alu_b :
                      (alu_ctrl == SUBU) ? alu_a - alu_b : 32'h0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: architectural results from plain arithmetic, returned as {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    logic [63:0] res;
    case (o)
      2'b00: res = {32'h0, a} * {32'h0, b};
      2'b01: begin
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p;
      end
      2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
    endcase
    return res;
  endfunction

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic lo_wr, input logic [31:0] wd);
    exp_t        e;
    logic [63:0] r;
    logic        dz;
    wait_idle();
    r           = ref_model(o, a, b);
    dz          = o[1] && (b == 0);
    e.hi        = r[63:32];
    e.lo        = r[31:0];
    e.start_cyc = cyc + 1;
    e.lat       = dz ? 1 : 34;
    e.busy_n    = dz ? 1 : 34;
    e.addu_n    = dz ? 1 : (o[1] ? 2 : 34);
    e.subu_n    = (o[1] && !dz) ? 32 : 0;
    exp_q.push_back(e);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    lo_we  = lo_wr;
    wdata  = wd;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    if (lo_wr) check("lo_we_with_start", lo, model_lo);
    model_hi  = e.hi;
    model_lo  = e.lo;
    exp_perf += e.busy_n;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  always @(posedge rst) begin
    busy_n = 0;
    addu_n = 0;
    subu_n = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy) busy_n++;
      if (busy && alu_ctrl == ADDU) addu_n++;
      if (busy && alu_ctrl == SUBU) subu_n++;
      if (!busy && (alu_a != 0 || alu_b != 0 || alu_ctrl != ADDU)) idle_bad++;
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_hi", hi, e.hi);
          check("res_lo", lo, e.lo);
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_cycles", busy_n, e.busy_n);
          check("addu_cycles", addu_n, e.addu_n);
          check("subu_cycles", subu_n, e.subu_n);
        end
        busy_n = 0;
        addu_n = 0;
        subu_n = 0;
      end
    end
  end

  initial begin
    int n;
    tests = 0; fails = 0; idle_bad = 0; exp_perf = 0;
    busy_n = 0; addu_n = 0; subu_n = 0;
    model_hi = 0; model_lo = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 0; rt_val = 0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_alu", {alu_a, alu_b, alu_ctrl}, {32'h0, 32'h0, ADDU});
    rst = 1'b0;
    @(negedge clk);

    // directed operations
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    issue(2'b10, 32'd100, 32'd7, 1'b0, 0);
    issue(2'b10, 32'h1234, 32'd0, 1'b0, 0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    issue(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 0);

    // MTHI in IDLE, then writes during busy must be ignored
    wait_idle();
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hA5A5_A5A5);
    model_hi = 32'hA5A5_A5A5;
    lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h0BAD_F00D);
    model_lo = 32'h0BAD_F00D;
    issue(2'b00, 32'd123456, 32'd789, 1'b1, 32'h5A5A_5A5A);
    repeat (5) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;

    // asynchronous reset in the middle of ITER (counter = 10)
    issue(2'b00, $urandom, $urandom, 1'b0, 0);
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_alu", {alu_a, alu_b, alu_ctrl}, {32'h0, 32'h0, ADDU});
    exp_q.delete();
    model_hi = 0; model_lo = 0; exp_perf = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 1'b0, 0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    check("idle_alu", idle_bad, 0);
    check("final_hi", hi, model_hi);
    check("final_lo", lo, model_lo);
`ifdef MULDIV_PERF_EN
    check("perf_cycles", perf_cycles, exp_perf);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
